legv8_fetch_unit: RTL
=====================

// Module: legv8_fetch_unit
// PURPOSE
//   Instruction fetch engine for the LEGv8 core: owns the program counter.
//   Issues one word-aligned read at a time to instruction memory over a
//   valid/ready request channel, captures the response, and presents
//   {instr, pc} to decode over a valid/ready channel.
//   Accepts branch/exception redirects from execute and discards stale fetches.
// PARAMETERS
//   ADDR_W    32  width of PC and instruction-memory address
//   INSTR_W   32  instruction word width
//   RESET_PC  0   PC value loaded on reset; must be 4-byte aligned
// PORTS
//   clk             in   1        rising-edge clock
//   reset           in   1        reset, synchronous, active-high
//   redirect_valid  in   1        load new PC this cycle (branch taken / flush)
//   redirect_pc     in   ADDR_W   redirect target; bits [1:0] ignored, forced 0
//   imem_req_valid  out  1        read request valid
//   imem_req_addr   out  ADDR_W   read address (= pc)
//   imem_req_ready  in   1        memory accepts request
//   imem_rsp_valid  in   1        read data valid (1-cycle pulse per request)
//   imem_rsp_data   in   INSTR_W  read data
//   if_valid        out  1        fetched instruction valid to decode
//   if_instr        out  INSTR_W  fetched instruction
//   if_pc           out  ADDR_W   address of if_instr
//   if_ready        in   1        decode accepts instruction
// BEHAVIOUR
//   States: IDLE, FETCH, WAIT, HOLD, DRAIN. At most one request outstanding.
//   Reset: state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0,
//     imem_req_valid=0. Reset mid-operation abandons any outstanding read.
//     The first response after reset is not discarded, so memory must drop
//     in-flight reads on reset.
//   IDLE -> FETCH unconditionally. First request is on cycle 2 after reset release.
//   FETCH: imem_req_valid=1, imem_req_addr=pc. req_ready=1 -> latch req_pc=pc, WAIT.
//   WAIT: rsp_valid=1 -> if_instr<=rsp_data, if_pc<=req_pc, if_valid<=1,
//     pc<=pc+4, HOLD. Response is never accepted in the acceptance cycle.
//   HOLD: if_valid=1, outputs stable. if_ready=1 -> if_valid<=0, FETCH.
//   DRAIN: rsp_valid=1 -> discard data, FETCH. if_valid=0 throughout.
//   Redirect: highest priority, any non-IDLE state. pc<=redirect_pc&~3.
//     WAIT or DRAIN, or FETCH with req_ready=1 -> DRAIN (stale read pending).
//     FETCH with req_ready=0, or HOLD -> FETCH.
//     HOLD: if_valid<=0. If if_ready=1 in the same cycle, the handshake
//     still completes; decode owns that flush.
//     Simultaneous rsp_valid in WAIT: the response is dropped, state FETCH.
//     rsp_valid in DRAIN: the response is dropped, state FETCH.
//   Arithmetic: pc+4 modulo 2^ADDR_W; 0xFFFFFFFC+4 -> 0x00000000, no flag.
//   rsp_valid outside WAIT/DRAIN is ignored.
//   imem_req_valid is deasserted only by acceptance, redirect or reset.
//   Best-case throughput: 1 instr / 3 cycles (FETCH, WAIT, HOLD).
// TESTING
//   1 Reset, RESET_PC=0x100, 0-wait memory, if_ready=1 -> if_pc 0x100,
//     0x104, 0x108 with matching memory words; first request 2 cycles after reset.
//   2 Hold if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc
//     stable; no new imem request until if_ready=1.
//   3 Redirect to 0x2003 while in WAIT; stale response arrives later ->
//     response discarded; next if_pc=0x2000.
//   4 Redirect with rsp_valid in the same cycle -> no if_valid pulse;
//     next request address = redirect target.
//   5 RESET_PC=0xFFFFFFF8 -> if_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
//   6 Assert reset in HOLD with if_valid=1 -> next cycle if_valid=0,
//     imem_req_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/legv8_fetch_unit.sv
// LEGv8 instruction fetch engine: owns the PC, issues one instruction-memory
// read at a time and hands {instr, pc} to decode over a valid/ready channel.
module legv8_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req_valid,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    input  logic                if_ready
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               redirect_take;
    logic               rsp_capture;

    // Redirects are ignored in IDLE; a response that coincides with a redirect is stale.
    assign redirect_take = redirect_valid && (state != IDLE);
    assign rsp_capture   = (state == WAIT) && imem_rsp_valid && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    next_state = imem_req_ready ? DRAIN : FETCH;
                end else if (imem_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    next_state = imem_rsp_valid ? FETCH : DRAIN;
                end else if (imem_rsp_valid) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || if_ready) begin
                    next_state = FETCH;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            if (redirect_take) begin
                pc <= redirect_pc & ~ADDR_W'(3);
            end else if (rsp_capture) begin
                pc <= pc + ADDR_W'(4);
            end
            if ((state == FETCH) && imem_req_ready) begin
                req_pc <= pc;
            end
            if (rsp_capture) begin
                if_instr <= imem_rsp_data;
                if_pc    <= req_pc;
            end
        end
    end

    // if_valid is high exactly while an instruction is parked in HOLD.
    always_comb begin
        imem_req_valid = (state == FETCH);
        imem_req_addr  = pc;
        if_valid       = (state == HOLD);
    end

endmodule
